// File: rtl/gearbox_pkg.sv
// Shared constants and types for the 32-to-24 and 24-to-32 byte gearboxes.
package gearbox_pkg;

    localparam int unsigned IN_BYTES  = 4;
    localparam int unsigned OUT_BYTES = 3;
    localparam int unsigned BUF_BYTES = 6;

    localparam int unsigned IN_W  = 8 * IN_BYTES;
    localparam int unsigned OUT_W = 8 * OUT_BYTES;
    localparam int unsigned BUF_W = 8 * BUF_BYTES;
    localparam int unsigned OCC_W = 3;
    localparam int unsigned CNT_W = 2;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } gb_state_e;

    // Keep only the lowest n bytes of an output word.
    function automatic logic [OUT_W-1:0] byte_mask(input logic [CNT_W-1:0] n);
        case (n)
            2'd1:    byte_mask = OUT_W'(24'h0000FF);
            2'd2:    byte_mask = OUT_W'(24'h00FFFF);
            default: byte_mask = OUT_W'(24'hFFFFFF);
        endcase
    endfunction

endpackage

// File: rtl/gearbox_32_24_reset_sync.sv
// Two-flop reset synchroniser: asserts asynchronously, releases on the second clk edge.
module reset_sync (
    input  logic clk,
    input  logic reset_n,
    output logic reset_sync_n
);

    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], 1'b1};
        end
    end

    assign reset_sync_n = sync_q[1];

endmodule

// File: rtl/gearbox_32_24.sv
// 32-bit to 24-bit packet gearbox with a 6-byte buffer and end-of-packet flush.
module gearbox_32_24
    import gearbox_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic [IN_W-1:0]  data_in,
    input  logic             data_in_en,
    input  logic             data_in_last,
    output logic             data_in_rdy,
    output logic [OUT_W-1:0] data_out,
    output logic             data_out_en,
    output logic             data_out_last,
    output logic [CNT_W-1:0] data_out_bytes
);

    logic             rst_int_n;
    gb_state_e        state_q;
    gb_state_e        state_d;
    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_d;
    logic [OCC_W-1:0] rem_occ;
    logic [BUF_W-1:0] buf_q;
    logic [BUF_W-1:0] buf_d;
    logic [BUF_W-1:0] shifted;
    logic [CNT_W-1:0] bytes_d;
    logic             accept;
    logic             emit_full;
    logic             emit_last;

    reset_sync u_reset_sync (
        .clk          (clk),
        .reset_n      (reset_n),
        .reset_sync_n (rst_int_n)
    );

    assign data_in_rdy = rst_int_n && (state_q == RUN) && (occ_q <= OCC_W'(5));

    // In RUN a full word leaves whenever 3 bytes are present; in FLUSH the
    // final 1..3 bytes leave as the tagged last word.
    always_comb begin
        accept    = data_in_en && data_in_rdy;
        emit_full = (state_q == RUN) ? (occ_q >= OCC_W'(3)) : (occ_q > OCC_W'(3));
        emit_last = (state_q == FLUSH) && (occ_q != '0) && (occ_q <= OCC_W'(3));
        rem_occ   = occ_q;
        shifted   = buf_q;
        if (emit_full) begin
            rem_occ = occ_q - OCC_W'(3);
            shifted = BUF_W'(buf_q >> (8 * OUT_BYTES));
        end else if (emit_last) begin
            rem_occ = '0;
            shifted = '0;
        end
        buf_d = shifted;
        occ_d = rem_occ;
        if (accept) begin
            buf_d = shifted | (BUF_W'(data_in) << {rem_occ, 3'b000});
            occ_d = rem_occ + OCC_W'(IN_BYTES);
        end
        state_d = state_q;
        if (accept && data_in_last) begin
            state_d = FLUSH;
        end else if (emit_last || ((state_q == FLUSH) && (occ_q == '0))) begin
            state_d = RUN;
        end
        bytes_d = emit_full ? CNT_W'(3) : (emit_last ? occ_q[CNT_W-1:0] : CNT_W'(0));
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q        <= RUN;
            occ_q          <= '0;
            buf_q          <= '0;
            data_out       <= '0;
            data_out_en    <= 1'b0;
            data_out_last  <= 1'b0;
            data_out_bytes <= '0;
        end else begin
            state_q        <= state_d;
            occ_q          <= occ_d;
            buf_q          <= buf_d;
            data_out_en    <= emit_full || emit_last;
            data_out_last  <= emit_last;
            data_out_bytes <= bytes_d;
            if (emit_full || emit_last) begin
                data_out <= buf_q[OUT_W-1:0] & byte_mask(bytes_d);
            end
        end
    end

endmodule

// File: doc/gearbox_32_24.md
GEARBOX_32_24 -- requirements
Module: gearbox_32_24

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  sole clock; all state on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 data_in  input  32  input word; byte 0 = data_in[7:0], byte 3 = data_in[31:24].
REQ-005 data_in_en  input  1  input word valid.
REQ-006 data_in_last  input  1  marks final word of packet; qualified by data_in_en.
REQ-007 data_in_rdy  output  1  block can accept a word this cycle.
REQ-008 data_out  output  24  output word; byte 0 = data_out[7:0]; unused upper bytes are zero.
REQ-009 data_out_en  output  1  data_out valid; single-cycle qualifier, no downstream backpressure.
REQ-010 data_out_last  output  1  final output word of packet; qualified by data_out_en.
REQ-011 data_out_bytes  output  2  valid byte count of data_out (1..3); 3 on every non-last word.

Function
REQ-012 A word SHALL be accepted on a rising edge where data_in_en and data_in_rdy are both high; data_in_en with data_in_rdy low SHALL be ignored.
REQ-013 A 48-bit byte buffer with a 3-bit occupancy count (0..6 bytes) SHALL hold unconsumed bytes, oldest byte in the lowest position.
REQ-014 A state machine SHALL have two states, RUN and FLUSH; reset enters RUN.
REQ-015 data_in_rdy SHALL be driven combinationally from registers as (state==RUN) && (occupancy<=5).
REQ-016 Each edge with occupancy>=3 SHALL emit the lowest 3 buffer bytes.
  - Emission sets data_out_en=1 and data_out_bytes=3 on the following cycle.
  - The buffer shifts down by 3 bytes.
REQ-017 An accepted word SHALL be appended above the bytes remaining after any same-edge emission; occupancy becomes occ - 3*emit + 4 and never exceeds 6.
REQ-018 Latency: a byte accepted on edge N SHALL appear on data_out no earlier than after edge N+1.
REQ-019 Steady-state throughput SHALL be 3 words accepted per 4 output words under continuous data_in_en.
REQ-020 Accepting a word with data_in_last=1 SHALL move the state to FLUSH; no new words are accepted in FLUSH.
REQ-021 In FLUSH, full 3-byte words SHALL be emitted while occupancy>3.
REQ-022 In FLUSH, the packet's final output word is emitted on the edge where occupancy is 1..3.
  - It carries data_out_last=1 and data_out_bytes equal to the remaining count.
  - Bytes above that count are zero.
  - Occupancy returns to 0 and state returns to RUN.
REQ-023 data_out_en, data_out_last and data_out_bytes SHALL be registered; on cycles without emission they are 0, 0, 0, and data_out holds its last value.
REQ-024 A packet of W words SHALL produce exactly ceil(4W/3) output words with exactly one data_out_last.

Reset
REQ-025 reset_n low SHALL asynchronously clear the following:
  - state to RUN
  - occupancy to 0
  - buffer to 0
  - data_out to 0
  - data_out_en, data_out_last and data_out_bytes to 0
REQ-026 Reset deassertion SHALL be synchronised to clk through two flops before releasing internal state.
REQ-027 Reset asserted mid-packet SHALL discard all buffered bytes with no partial last emitted.
REQ-028 data_in_rdy SHALL be low while reset is asserted and during the synchroniser release cycles.

Structure
REQ-029 Byte-width constants SHALL live in shared package gearbox_pkg, alongside those used by the 24-to-32 gearbox:
  - IN_BYTES=4
  - OUT_BYTES=3
  - BUF_BYTES=6
REQ-030 The FSM state enum SHALL also live in gearbox_pkg.
REQ-031 The reset synchroniser SHALL be the single sub-module reset_sync; all other logic is flat in gearbox_32_24.

Verification
REQ-032 3-word packet 0x03020100, 0x07060504, 0x0B0A0908 (last on third) -> 0x020100, 0x050403, 0x080706, 0x0B0A09; last on fourth, bytes=3.
REQ-033 1-word packet 0xDDCCBBAA -> 0xCCBBAA (bytes=3), then 0x0000DD (bytes=1, last=1); data_in_rdy low until the last word is emitted.
REQ-034 2-word packet 0x44332211, 0x88776655 -> 0x332211, 0x665544, 0x008877 (bytes=2, last=1).
REQ-035 Continuous 12-word stream with data_in_en held high -> 9 words accepted per 12 cycles.
  - data_in_rdy low whenever occupancy=6.
  - No byte lost or duplicated.
REQ-036 reset_n pulsed low after 2 words of a packet, then a new 1-word packet -> no output from the aborted packet; new packet output as in REQ-033.
